// File: rtl/register_bank_rd.sv
// Register bank: single-cycle write port plus a valid/ready read port whose
// answer sits in a one-entry response buffer that holds under backpressure.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no response held; rd_rsp_valid=0, next request always accepted
// ST_FULL  | response held in r_data/r_err until the consumer takes it
module register_bank_rd #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req_valid,
   output logic             rd_req_ready,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_rsp_valid,
   input  logic             rd_rsp_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_err
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data;
   logic             r_err;

   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_accept;
   logic [WIDTH-1:0] w_rd_sel;

   assign w_wr_ok  = ({1'b0, wr_addr} < DEPTH_L);
   assign w_rd_ok  = ({1'b0, rd_addr} < DEPTH_L);
   assign w_accept = rd_req_valid && rd_req_ready;

   // Write-first: a same-edge write to the requested entry is forwarded.
   always_comb begin
      w_rd_sel = '0;
      if (w_rd_ok) begin
         if (wr_en && w_wr_ok && (wr_addr == rd_addr))
            w_rd_sel = wr_data;
         else
            w_rd_sel = r_mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (wr_en && w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_data <= w_rd_sel;
         r_err  <= !w_rd_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   // rd_req_ready depends only on the buffer state and rd_rsp_ready.
   always_comb begin
      w_state_nxt  = r_state;
      rd_rsp_valid = 1'b0;
      rd_req_ready = 1'b1;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept)
               w_state_nxt = ST_FULL;
         end
         ST_FULL: begin
            rd_rsp_valid = 1'b1;
            rd_req_ready = rd_rsp_ready;
            if (rd_rsp_ready && !w_accept)
               w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   assign rd_data = r_data;
   assign rd_err  = r_err;

endmodule
